// File: rtl/rv_iopmp_check_arbiter.sv
// Round-robin arbiter/sequencer sharing one IOPMP transaction checker between
// NUM_REQ requester ports, with a hung-check timeout that forces a deny.

package rv_iopmp_check_arbiter_pkg;
    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;
endpackage

module rv_iopmp_check_arbiter
    import rv_iopmp_check_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int NB            = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][NB-1:0]           req_num_bytes_i,
    input  logic [NUM_REQ-1:0][SID_WIDTH-1:0]    req_sid_i,
    input  access_t [NUM_REQ-1:0]                req_access_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    input  logic [NUM_REQ-1:0]                   rsp_ready_i,
    output logic                                 rsp_allow_o,
    output logic                                 rsp_timeout_o,
    output logic                                 chk_en_o,
    output logic [ADDR_WIDTH-1:0]                chk_addr_o,
    output logic [NB-1:0]                        chk_num_bytes_o,
    output logic [SID_WIDTH-1:0]                 chk_sid_o,
    output access_t                              chk_access_o,
    input  logic                                 chk_ready_i,
    input  logic                                 chk_valid_i,
    input  logic                                 chk_allow_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0] grant_reg, grant_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             allow_reg, allow_next;
    logic             timeout_reg, timeout_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [NB-1:0]         num_bytes_reg;
    logic [SID_WIDTH-1:0]  sid_reg;
    access_t               access_reg;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             grant_fire;
    logic             chk_done;
    logic             chk_done_allow;
    logic             checking;
    logic             timer_hit;

    // Scan offsets from the highest down so the smallest offset from the
    // round-robin pointer is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_idx = IDX_W'((int'(rr_ptr_reg) + i) % NUM_REQ);
            if (req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign checking  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_BUSY) ||
                       (state_reg == ST_WAIT_DONE);
    assign timer_hit = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        timer_next     = timer_reg;
        allow_next     = allow_reg;
        timeout_next   = timeout_reg;
        grant_fire     = 1'b0;
        chk_done       = 1'b0;
        chk_done_allow = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    grant_fire   = 1'b1;
                    grant_next   = grant_idx;
                    rr_ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    timer_next   = '0;
                    allow_next   = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (chk_ready_i) begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A single-cycle checker never drops ready; its valid pulse completes here.
                if (!chk_ready_i) begin
                    state_next = ST_WAIT_DONE;
                end else if (chk_valid_i) begin
                    chk_done       = 1'b1;
                    chk_done_allow = chk_allow_i;
                end
            end
            ST_WAIT_DONE: begin
                if (chk_ready_i) begin
                    chk_done       = 1'b1;
                    chk_done_allow = chk_valid_i & chk_allow_i;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i[grant_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Completion takes priority over a timeout landing in the same cycle.
        if (checking) begin
            timer_next = timer_reg + 1'b1;
            if (chk_done) begin
                state_next   = ST_RESP;
                allow_next   = chk_done_allow;
                timeout_next = 1'b0;
            end else if (timer_hit) begin
                state_next   = ST_RESP;
                allow_next   = 1'b0;
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            timer_reg     <= '0;
            allow_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            addr_reg      <= '0;
            num_bytes_reg <= '0;
            sid_reg       <= '0;
            access_reg    <= ACCESS_NONE;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            grant_reg   <= grant_next;
            timer_reg   <= timer_next;
            allow_reg   <= allow_next;
            timeout_reg <= timeout_next;
            if (grant_fire) begin
                addr_reg      <= req_addr_i[grant_idx];
                num_bytes_reg <= req_num_bytes_i[grant_idx];
                sid_reg       <= req_sid_i[grant_idx];
                access_reg    <= req_access_i[grant_idx];
            end
        end
    end

    assign chk_en_o        = (state_reg == ST_ISSUE) && chk_ready_i;
    assign chk_addr_o      = addr_reg;
    assign chk_num_bytes_o = num_bytes_reg;
    assign chk_sid_o       = sid_reg;
    assign chk_access_o    = access_reg;
    assign rsp_allow_o     = (state_reg == ST_RESP) && allow_reg;
    assign rsp_timeout_o   = (state_reg == ST_RESP) && timeout_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign req_ready_o[gi] = (state_reg == ST_IDLE) && grant_found &&
                                 (grant_idx == IDX_W'(gi));
        assign rsp_valid_o[gi] = (state_reg == ST_RESP) && (grant_reg == IDX_W'(gi));
    end

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Bench for rv_iopmp_check_arbiter: a transaction-level model checked every
// cycle, a small behavioural checker, and directed scenarios with literal expectations.

module tb_rv_iopmp_check_arbiter;
    import rv_iopmp_check_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int TO = 256;
    localparam int NB = 4;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [N-1:0]          req_valid_i;
    logic [N-1:0]          req_ready_o;
    logic [N-1:0][AW-1:0]  req_addr_i;
    logic [N-1:0][NB-1:0]  req_num_bytes_i;
    logic [N-1:0][SW-1:0]  req_sid_i;
    access_t [N-1:0]       req_access_i;
    logic [N-1:0]          rsp_valid_o;
    logic [N-1:0]          rsp_ready_i;
    logic                  rsp_allow_o;
    logic                  rsp_timeout_o;
    logic                  chk_en_o;
    logic [AW-1:0]         chk_addr_o;
    logic [NB-1:0]         chk_num_bytes_o;
    logic [SW-1:0]         chk_sid_o;
    access_t               chk_access_o;
    logic                  chk_ready_i;
    logic                  chk_valid_i;
    logic                  chk_allow_i;

    rv_iopmp_check_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_num_bytes_i(req_num_bytes_i),
        .req_sid_i(req_sid_i), .req_access_i(req_access_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_allow_o(rsp_allow_o), .rsp_timeout_o(rsp_timeout_o),
        .chk_en_o(chk_en_o), .chk_addr_o(chk_addr_o), .chk_num_bytes_o(chk_num_bytes_o),
        .chk_sid_o(chk_sid_o), .chk_access_o(chk_access_o),
        .chk_ready_i(chk_ready_i), .chk_valid_i(chk_valid_i), .chk_allow_i(chk_allow_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Behavioural checker: on enable it goes busy for cfg_busy cycles, then
    // returns to ready with an optional valid pulse; cfg_one answers in one cycle.
    int cfg_busy  = 2;
    bit cfg_valid = 1'b1;
    bit cfg_allow = 1'b1;
    bit cfg_one   = 1'b0;

    initial begin : checker_model
        int ck_left;
        bit ck_start;
        ck_left     = 0;
        chk_ready_i = 1'b1;
        chk_valid_i = 1'b0;
        chk_allow_i = 1'b0;
        forever begin
            @(negedge clk);
            ck_start = (rst_ni === 1'b1) && (chk_en_o === 1'b1);
            @(posedge clk);
            #1;
            chk_valid_i = 1'b0;
            if (ck_start) begin
                if (cfg_one) begin
                    chk_valid_i = 1'b1;
                    chk_allow_i = cfg_allow;
                end else begin
                    chk_ready_i = 1'b0;
                    ck_left     = cfg_busy;
                end
            end else if (ck_left > 0) begin
                ck_left--;
                if (ck_left == 0) begin
                    chk_ready_i = 1'b1;
                    chk_valid_i = cfg_valid;
                    chk_allow_i = cfg_allow;
                end
            end
        end
    end

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model: phase 0 = free, 1 = check outstanding, 2 = verdict offered.
    initial begin : compare
        int            g;
        int            m_phase, m_ptr, m_owner, m_cyc;
        bit            m_en_seen, m_busy_seen, m_allow, m_to;
        logic [AW-1:0] m_addr;
        logic [NB-1:0] m_nb;
        logic [SW-1:0] m_sid;
        access_t       m_acc;
        logic [N-1:0]  e_ready, e_rsp;
        m_phase = 0; m_ptr = 0; m_owner = 0; m_cyc = 0;
        m_en_seen = 0; m_busy_seen = 0; m_allow = 0; m_to = 0;
        m_addr = '0; m_nb = '0; m_sid = '0; m_acc = ACCESS_NONE;
        forever begin
            @(negedge clk);
            if (rst_ni !== 1'b1) begin
                check("rst req_ready", req_ready_o, 0);
                check("rst rsp_valid", rsp_valid_o, 0);
                check("rst rsp_allow", rsp_allow_o, 0);
                check("rst rsp_timeout", rsp_timeout_o, 0);
                check("rst chk_en", chk_en_o, 0);
                check("rst chk_addr", chk_addr_o, 0);
                check("rst chk_num_bytes", chk_num_bytes_o, 0);
                check("rst chk_sid", chk_sid_o, 0);
                check("rst chk_access", 64'(chk_access_o), 64'(ACCESS_NONE));
                m_phase = 0;
                m_ptr   = 0;
            end else begin
                g       = pick(req_valid_i, m_ptr);
                e_ready = (m_phase == 0 && g >= 0) ? N'(1 << g) : '0;
                e_rsp   = (m_phase == 2) ? N'(1 << m_owner) : '0;
                check("req_ready", req_ready_o, e_ready);
                check("chk_en", chk_en_o, (m_phase == 1) && !m_en_seen && chk_ready_i);
                check("rsp_valid", rsp_valid_o, e_rsp);
                check("rsp_allow", rsp_allow_o, (m_phase == 2) && m_allow);
                check("rsp_timeout", rsp_timeout_o, (m_phase == 2) && m_to);
                if (m_phase != 0) begin
                    check("chk_addr", chk_addr_o, m_addr);
                    check("chk_num_bytes", chk_num_bytes_o, m_nb);
                    check("chk_sid", chk_sid_o, m_sid);
                    check("chk_access", 64'(chk_access_o), 64'(m_acc));
                end
                if (chk_en_o === 1'b1) en_count++;
                case (m_phase)
                    0: if (g >= 0) begin
                        m_owner = g;
                        m_addr  = req_addr_i[g];
                        m_nb    = req_num_bytes_i[g];
                        m_sid   = req_sid_i[g];
                        m_acc   = req_access_i[g];
                        m_ptr   = (g + 1) % N;
                        m_phase = 1;
                        m_cyc   = 0;
                        m_en_seen   = 0;
                        m_busy_seen = 0;
                    end
                    1: begin
                        // Done = checker ready again after the enable, having been busy or pulsing valid.
                        if (m_en_seen && chk_ready_i && (m_busy_seen || chk_valid_i)) begin
                            m_phase = 2;
                            m_allow = chk_valid_i && chk_allow_i;
                            m_to    = 0;
                        end else if (m_cyc == TO - 1) begin
                            m_phase = 2;
                            m_allow = 0;
                            m_to    = 1;
                        end else begin
                            if (!m_en_seen) m_en_seen = chk_ready_i;
                            else if (!chk_ready_i) m_busy_seen = 1;
                            m_cyc++;
                        end
                    end
                    default: if (rsp_ready_i[m_owner]) m_phase = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [NB-1:0] nb,
                            input logic [SW-1:0] s, input access_t ac);
        req_addr_i[p]      = a;
        req_num_bytes_i[p] = nb;
        req_sid_i[p]       = s;
        req_access_i[p]    = ac;
    endtask

    task automatic wait_grant(input string name, output int gcyc, output logic [N-1:0] gvec);
        gcyc = cyc;
        gvec = '0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (|req_ready_o) begin
                gcyc = cyc;
                gvec = req_ready_o;
                return;
            end
        end
        bound_expired(name);
    endtask

    task automatic wait_rsp(input string name, input int p, output int rcyc,
                            output logic allow, output logic tmo);
        rcyc  = cyc;
        allow = 1'b0;
        tmo   = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rsp_valid_o[p] === 1'b1) begin
                rcyc  = cyc;
                allow = rsp_allow_o;
                tmo   = rsp_timeout_o;
                return;
            end
        end
        bound_expired(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           gc, rc, c0, e0;
        logic [N-1:0] gv;
        logic         al, tm;
        logic [N-1:0] t2_exp [5];
        t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_ni      = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '1;
        for (int p = 0; p < N; p++) set_port(p, '0, '0, '0, ACCESS_NONE);
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        // Single request on port 1, checker busy for 2 cycles then allows.
        set_port(1, 64'h8000_0000, 4'd8, 8'h21, ACCESS_READ);
        cfg_busy = 2; cfg_valid = 1; cfg_allow = 1; cfg_one = 0;
        e0 = en_count; c0 = cyc;
        req_valid_i[1] = 1'b1;
        wait_grant("t1 grant wait", gc, gv);
        check("t1 grant vector", gv, 4'b0010);
        check("t1 grant same cycle", gc - c0, 0);
        step();
        req_valid_i[1] = 1'b0;
        wait_rsp("t1 rsp wait", 1, rc, al, tm);
        check("t1 latency", rc - gc, 5);
        check("t1 allow", al, 1);
        check("t1 timeout", tm, 0);
        step();
        check("t1 enable pulses", en_count - e0, 1);

        // One-cycle checker on port 3: minimum latency.
        set_port(3, 64'h0000_1234_0000_0040, 4'd1, 8'h33, ACCESS_WRITE);
        cfg_one = 1;
        req_valid_i[3] = 1'b1;
        wait_grant("t1b grant wait", gc, gv);
        check("t1b grant vector", gv, 4'b1000);
        step();
        req_valid_i[3] = 1'b0;
        wait_rsp("t1b rsp wait", 3, rc, al, tm);
        check("t1b latency", rc - gc, 3);
        check("t1b allow", al, 1);
        step();

        // All ports valid continuously, immediate acceptance.
        cfg_one = 0; cfg_busy = 1;
        for (int p = 0; p < N; p++)
            set_port(p, 64'(64'h1000 * (p + 1)), NB'(p), SW'(8'h10 + p), access_t'(p));
        e0 = en_count;
        req_valid_i = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2 grant wait", gc, gv);
            check($sformatf("t2 grant %0d", k), gv, t2_exp[k]);
        end
        step();
        req_valid_i = '0;
        wait_rsp("t2 rsp wait", 0, rc, al, tm);
        step();
        check("t2 enable pulses", en_count - e0, 5);

        // Checker returns to ready with no valid pulse: deny, no timeout.
        cfg_busy = 3; cfg_valid = 0; cfg_allow = 1;
        req_valid_i[0] = 1'b1;
        wait_grant("t3 grant wait", gc, gv);
        check("t3 grant vector", gv, 4'b0001);
        step();
        req_valid_i[0] = 1'b0;
        wait_rsp("t3 rsp wait", 0, rc, al, tm);
        check("t3 latency", rc - gc, 6);
        check("t3 allow", al, 0);
        check("t3 timeout", tm, 0);
        step();

        // Hung checker: forced deny 256 cycles after issue entry.
        cfg_busy = 300; cfg_valid = 1;
        req_valid_i[2] = 1'b1;
        wait_grant("t4 grant wait", gc, gv);
        check("t4 grant vector", gv, 4'b0100);
        step();
        req_valid_i[2] = 1'b0;
        wait_rsp("t4 rsp wait", 2, rc, al, tm);
        check("t4 latency", rc - gc, 1 + TO);
        check("t4 allow", al, 0);
        check("t4 timeout", tm, 1);
        step();

        // Verdict held for 10 cycles while ports 0 and 3 request.
        cfg_busy = 2;
        rsp_ready_i = '0;
        req_valid_i[1] = 1'b1;
        wait_grant("t5 grant wait", gc, gv);
        check("t5 grant vector", gv, 4'b0010);
        step();
        req_valid_i[1] = 1'b0;
        req_valid_i[0] = 1'b1;
        req_valid_i[3] = 1'b1;
        wait_rsp("t5 rsp wait", 1, rc, al, tm);
        step();
        e0 = en_count;
        repeat (10) step();
        check("t5 enables while held", en_count - e0, 0);
        check("t5 rsp_valid held", rsp_valid_o, 4'b0010);
        check("t5 allow held", rsp_allow_o, 1);
        rsp_ready_i = '1;
        wait_grant("t5 next grant wait", gc, gv);
        check("t5 next grant", gv, 4'b1000);
        step();
        req_valid_i[3] = 1'b0;
        wait_grant("t5 following grant wait", gc, gv);
        check("t5 following grant", gv, 4'b0001);
        step();
        req_valid_i[0] = 1'b0;
        wait_rsp("t5 final rsp wait", 0, rc, al, tm);
        step();

        // Reset while waiting on the checker; next grant restarts from port 0.
        cfg_busy = 20;
        req_valid_i[2] = 1'b1;
        wait_grant("t6 grant wait", gc, gv);
        check("t6 grant vector", gv, 4'b0100);
        step();
        req_valid_i[2] = 1'b0;
        repeat (5) step();
        rst_ni = 1'b0;
        #1;
        check("t6 rsp_valid after reset", rsp_valid_o, 0);
        check("t6 chk_addr after reset", chk_addr_o, 0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        req_valid_i = 4'b1010;
        wait_grant("t6 post-reset grant wait", gc, gv);
        check("t6 post-reset grant", gv, 4'b0010);
        step();
        req_valid_i = '0;
        wait_rsp("t6 post-reset rsp wait", 1, rc, al, tm);
        check("t6 post-reset allow", al, 1);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
